// File: rtl/bk_sub_serial.sv
// bk_sub_serial: chunk-serial subtractor d = a - b - bin, one 8-bit Brent-Kung chunk per clock.
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_ni       synchronous active-low reset
//   in_valid_i   operand set valid
//   in_ready_o   block can accept operands (IDLE)
//   a_i, b_i     minuend and subtrahend, WIDTH bits
//   bin_i        borrow-in
//   out_valid_o  result valid (DONE)
//   out_ready_i  consumer accepts result
//   d_o          difference, modulo 2^WIDTH
//   bout_o       borrow-out, 1 iff unsigned a < b + bin
//   overflow_o   signed overflow of the subtraction

// bk_black_op: full carry operator, combines (g,p) of a high group with a lower group.
module bk_black_op (
    input  logic g_hi_i,
    input  logic p_hi_i,
    input  logic g_lo_i,
    input  logic p_lo_i,
    output logic g_o,
    output logic p_o
);
    assign g_o = g_hi_i | (p_hi_i & g_lo_i);
    assign p_o = p_hi_i & p_lo_i;
endmodule

// bk_gray_op: carry operator for groups reaching bit 0, where only the generate is needed.
module bk_gray_op (
    input  logic g_hi_i,
    input  logic p_hi_i,
    input  logic g_lo_i,
    output logic g_o
);
    assign g_o = g_hi_i | (p_hi_i & g_lo_i);
endmodule

// bk_add8: 8-bit Brent-Kung adder; carry-in is folded into the bit-0 generate term.
module bk_add8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       c_i,
    output logic [7:0] s_o,
    output logic       c_o
);
    logic [7:0] g, p, c;
    logic       g32, p32, g54, p54, g76, p76, g74, p74;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;
    // c[i] is the group generate over bits i..0 including the carry-in
    assign c[0] = g[0] | (p[0] & c_i);

    // up-sweep
    bk_gray_op  u_10 (.g_hi_i(g[1]), .p_hi_i(p[1]), .g_lo_i(c[0]), .g_o(c[1]));
    bk_black_op u_32 (.g_hi_i(g[3]), .p_hi_i(p[3]), .g_lo_i(g[2]), .p_lo_i(p[2]), .g_o(g32), .p_o(p32));
    bk_black_op u_54 (.g_hi_i(g[5]), .p_hi_i(p[5]), .g_lo_i(g[4]), .p_lo_i(p[4]), .g_o(g54), .p_o(p54));
    bk_black_op u_76 (.g_hi_i(g[7]), .p_hi_i(p[7]), .g_lo_i(g[6]), .p_lo_i(p[6]), .g_o(g76), .p_o(p76));
    bk_gray_op  u_30 (.g_hi_i(g32), .p_hi_i(p32), .g_lo_i(c[1]), .g_o(c[3]));
    bk_black_op u_74 (.g_hi_i(g76), .p_hi_i(p76), .g_lo_i(g54), .p_lo_i(p54), .g_o(g74), .p_o(p74));
    bk_gray_op  u_70 (.g_hi_i(g74), .p_hi_i(p74), .g_lo_i(c[3]), .g_o(c[7]));

    // down-sweep
    bk_gray_op  u_50 (.g_hi_i(g54), .p_hi_i(p54), .g_lo_i(c[3]), .g_o(c[5]));
    bk_gray_op  u_20 (.g_hi_i(g[2]), .p_hi_i(p[2]), .g_lo_i(c[1]), .g_o(c[2]));
    bk_gray_op  u_40 (.g_hi_i(g[4]), .p_hi_i(p[4]), .g_lo_i(c[3]), .g_o(c[4]));
    bk_gray_op  u_60 (.g_hi_i(g[6]), .p_hi_i(p[6]), .g_lo_i(c[5]), .g_o(c[6]));

    assign s_o = p ^ {c[6:0], c_i};
    assign c_o = c[7];
endmodule

module bk_sub_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] d_o,
    output logic             bout_o,
    output logic             overflow_o
);
    localparam int CHUNKS = WIDTH / 8;
    localparam int IW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [IW-1:0]    idx_q;
    logic             borrow_q, bout_q, ovf_q;
    logic [WIDTH-1:0] a_q, b_q, d_q;

    logic [7:0] a_chunk, nb_chunk, sum8;
    logic       cout8, borrow_d, ovf_d, last;

    // subtraction as a + ~b + ~borrow, one chunk per cycle
    assign a_chunk  = a_q[8*idx_q +: 8];
    assign nb_chunk = ~b_q[8*idx_q +: 8];

    bk_add8 u_add (
        .a_i(a_chunk),
        .b_i(nb_chunk),
        .c_i(~borrow_q),
        .s_o(sum8),
        .c_o(cout8)
    );

    assign borrow_d = ~cout8;
    assign last     = idx_q == IW'(CHUNKS - 1);
    // sum8[7] is the result MSB on the final chunk
    assign ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum8[7] != a_q[WIDTH-1]);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid_i) begin
                    a_q      <= a_i;
                    b_q      <= b_i;
                    borrow_q <= bin_i;
                    idx_q    <= '0;
                    state_q  <= RUN;
                end
                RUN: begin
                    d_q[8*idx_q +: 8] <= sum8;
                    borrow_q          <= borrow_d;
                    idx_q             <= idx_q + 1'b1;
                    if (last) begin
                        bout_q  <= borrow_d;
                        ovf_q   <= ovf_d;
                        state_q <= DONE;
                    end
                end
                DONE: if (out_ready_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = state_q == IDLE;
    assign out_valid_o = state_q == DONE;
    assign d_o         = d_q;
    assign bout_o      = bout_q;
    assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_bk_sub_serial.sv
// tb_bk_sub_serial: scoreboard bench for bk_sub_serial against an arithmetic reference model.
module tb_bk_sub_serial;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        bin_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] d_o;
    logic        bout_o;
    logic        overflow_o;

    int passed = 0;
    int total  = 0;
    logic [33:0] sb_q[$];

    bk_sub_serial #(.WIDTH(32)) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .a_i(a_i),
        .b_i(b_i),
        .bin_i(bin_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .d_o(d_o),
        .bout_o(bout_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // {overflow, bout, d}
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic bi);
        logic [32:0] diff;
        logic        ovf;
        diff = {1'b0, a} - {1'b0, b} - {32'd0, bi};
        ovf  = (a[31] != b[31]) && (diff[31] != a[31]);
        return {ovf, diff[32], diff[31:0]};
    endfunction

    // monitor: pops on every output handshake
    always @(negedge clk_i) begin
        if (rst_ni) begin
            chk("rdy_vld_exclusive", {63'd0, in_ready_o & out_valid_o}, 64'd0);
            if (out_valid_o && out_ready_i) begin
                if (sb_q.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
                else chk("result", {30'd0, overflow_o, bout_o, d_o}, {30'd0, sb_q.pop_front()});
            end
        end
    end

    // returns just after the acceptance edge
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic bi, input bit push);
        int n;
        a_i = a;
        b_i = b;
        bin_i = bi;
        in_valid_i = 1'b1;
        n = 0;
        while (!in_ready_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!in_ready_o) chk("accept_timeout", 64'd1, 64'd0);
        if (push) sb_q.push_back(model(a, b, bi));
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic wait_lat();
        int lat;
        lat = 0;
        while (!out_valid_o && lat < 20) begin
            @(posedge clk_i); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'd4);
    endtask

    task automatic drain(input bit rnd);
        bit hs;
        int n;
        n = 0;
        hs = 1'b0;
        while (!hs && n < 200) begin
            out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = out_valid_o && out_ready_i;
            @(posedge clk_i); #1;
            n++;
        end
        if (!hs) chk("drain_timeout", 64'd1, 64'd0);
        out_ready_i = 1'b0;
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic bi, input bit rnd);
        issue(a, b, bi, 1'b1);
        wait_lat();
        drain(rnd);
    endtask

    initial begin
        logic [33:0] e;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("reset_in_ready", {63'd0, in_ready_o}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("reset_outputs", {30'd0, overflow_o, bout_o, d_o}, 64'd0);

        op(32'h00000005, 32'h00000003, 1'b0, 1'b0);
        op(32'h00000000, 32'h00000001, 1'b0, 1'b0);
        op(32'h80000000, 32'h00000001, 1'b0, 1'b0);
        op(32'h00000100, 32'h000000FF, 1'b1, 1'b0);
        op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
        op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);

        // backpressure with a new operand set waiting
        e = model(32'hDEADBEEF, 32'h0BADF00D, 1'b0);
        issue(32'hDEADBEEF, 32'h0BADF00D, 1'b0, 1'b1);
        wait_lat();
        a_i = 32'h00001000;
        b_i = 32'h00002000;
        bin_i = 1'b1;
        in_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            chk("bp_out_valid", {63'd0, out_valid_o}, 64'd1);
            chk("bp_in_ready", {63'd0, in_ready_o}, 64'd0);
            chk("bp_hold", {30'd0, overflow_o, bout_o, d_o}, {30'd0, e});
        end
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        chk("bp_back_idle", {63'd0, in_ready_o}, 64'd1);
        op(32'h00001000, 32'h00002000, 1'b1, 1'b0);

        // reset after chunk 1
        issue(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        chk("rst_mid_in_ready", {63'd0, in_ready_o}, 64'd1);
        chk("rst_mid_out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rst_mid_outputs", {30'd0, overflow_o, bout_o, d_o}, 64'd0);
        op(32'h12345678, 32'h11111111, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++)
            op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);

        repeat (3) @(posedge clk_i);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bk_sub_serial.md
# bk_sub_serial

Multi-cycle, chunk-serial subtractor that computes `d = a - b - bin` over a WIDTH-bit operand one 8-bit chunk per clock. The borrow is chained in a register from one chunk to the next. Each chunk is evaluated as `a + ~b + ~borrow` through an 8-bit Brent-Kung prefix network built from the team's existing carry-operator cells. It is the subtract-direction counterpart of the combinational 8-bit BK adder and sits in the arithmetic datapath behind a valid/ready handshake on both sides.

## Interface
- `WIDTH`, default 32: operand width; must be a multiple of 8 and at least 8.
- `CHUNKS`, default `WIDTH/8`: derived, not overridable; number of compute cycles.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  operand set valid.
- `in_ready`  out  1  block can accept operands; equals (state == IDLE).
- `a`  in  WIDTH  minuend, unsigned/two's-complement.
- `b`  in  WIDTH  subtrahend.
- `bin`  in  1  borrow-in.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `d`  out  WIDTH  difference.
- `bout`  out  1  borrow-out; 1 iff unsigned `a < b + bin`.
- `overflow`  out  1  signed overflow: `a[MSB] != b[MSB]` and `d[MSB] != a[MSB]`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - When `in_valid` is high, the block captures `a`, `b`, `bin`, clears chunk index `idx` to 0, loads the borrow register with `bin`, and moves to RUN.
  - `in_valid` while not in IDLE is ignored.
- RUN, once per cycle:
  - Chunk `idx` computes `sum8 = a[8*idx+:8] + ~b[8*idx+:8] + ~borrow`. The carry-in is applied through the g0 term, as in the adder.
  - `d[8*idx+:8]` is written with `sum8`.
  - `borrow` is updated to `~cout8`.
  - `idx` increments.
  - On the cycle that processes `idx == CHUNKS-1`, the block writes `bout` with the final borrow and `overflow` per the rule above, then moves to DONE.
- DONE:
  - `out_valid`=1.
  - `d`, `bout`, `overflow` hold stable.
  - When `out_ready` is high, the block moves to IDLE.
- No overlap: the next operand set is accepted only in IDLE.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - Chunk-internal carry uses the BK prefix structure (generate/propagate from `a` and `~b`). Behavioural `-` or `+` on full width is not permitted.
  - `idx` width is `clog2(CHUNKS)`, minimum 1.
- Reset (`rst_n`=0 at an edge), including mid-RUN or in DONE:
  - state → IDLE
  - `idx`=0, `borrow`=0
  - `d`=0, `bout`=0, `overflow`=0, `out_valid`=0
  - A partially computed result is discarded and never presented.

## Timing
- Accept on edge T (IDLE, `in_valid`=1).
- Chunks 0..CHUNKS-1 are computed on edges T+1..T+CHUNKS.
- `out_valid` rises after edge T+CHUNKS, so latency = CHUNKS cycles (4 for WIDTH=32).
- With `out_ready` held high:
  - DONE lasts one cycle.
  - IDLE is reached after edge T+CHUNKS+1.
  - Throughput is one operation per CHUNKS+2 cycles.
- Backpressure: DONE persists indefinitely while `out_ready`=0, with outputs frozen.
- `out_ready` outside DONE has no effect.
- `in_ready` and `out_valid` are never both 1.
- After reset deassertion, `in_ready`=1 in the first cycle.
- Critical path per cycle: one 8-bit BK network plus the borrow register mux. No full-width carry path.

## Test plan
- Basic subtract, WIDTH=32: `a`=0x00000005, `b`=0x00000003, `bin`=0 → `d`=0x00000002, `bout`=0, `overflow`=0. `out_valid` asserts exactly 4 cycles after acceptance.
- Full borrow ripple: `a`=0x00000000, `b`=0x00000001, `bin`=0 → `d`=0xFFFFFFFF, `bout`=1, `overflow`=0.
- Signed overflow: `a`=0x80000000, `b`=0x00000001, `bin`=0 → `d`=0x7FFFFFFF, `bout`=0, `overflow`=1.
- Borrow-in across chunk boundary: `a`=0x00000100, `b`=0x000000FF, `bin`=1 → `d`=0x00000000, `bout`=0, `overflow`=0.
- Backpressure and no overlap: hold `out_ready`=0 for 5 cycles in DONE while `in_valid`=1 with new operands.
  - `out_valid`=1, `in_ready`=0, and `d`/`bout`/`overflow` stay unchanged.
  - After `out_ready` pulses, the new operands are accepted in the following IDLE cycle and produce the correct result.
- Reset mid-operation: assert `rst_n`=0 for one edge after chunk 1 of `a`=0x12345678, `b`=0x11111111.
  - Next cycle: `in_ready`=1, `out_valid`=0, `d`=0, `bout`=0.
  - A subsequent 0x12345678 − 0x11111111 yields `d`=0x01234567, `bout`=0.
